compute_t: RTL



---
 rtl/idct_pkg.sv | 27 ++
 rtl/compute_t_if.sv | 25 ++
 rtl/idct_coeff_rom.sv | 15 +
 rtl/compute_t.sv | 113 +++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - shared types and constants for the S' x C row transform
// C_TABLE rows are frequency k, columns spatial j: 12-bit IDCT magnitudes with cos signs.
package idct_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE_LAST,
    DONE
  } state_t;

  localparam int T_SHIFT = 8;
  localparam logic signed [31:0] ROUND_BIAS = 32'sd128;

  localparam logic signed [15:0] C_TABLE [8][8] = '{
    '{ 16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448},
    '{ 16'sd2008,  16'sd1702,  16'sd1137,  16'sd399,  -16'sd399,  -16'sd1137, -16'sd1702, -16'sd2008},
    '{ 16'sd1892,  16'sd783,  -16'sd783,  -16'sd1892, -16'sd1892, -16'sd783,   16'sd783,   16'sd1892},
    '{ 16'sd1702, -16'sd399,  -16'sd2008, -16'sd1137,  16'sd1137,  16'sd2008,  16'sd399,  -16'sd1702},
    '{ 16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448},
    '{ 16'sd1137, -16'sd2008,  16'sd399,   16'sd1702, -16'sd1702, -16'sd399,   16'sd2008, -16'sd1137},
    '{ 16'sd783,  -16'sd1892,  16'sd1892, -16'sd783,  -16'sd783,   16'sd1892, -16'sd1892,  16'sd783},
    '{ 16'sd399,  -16'sd1137,  16'sd1702, -16'sd2008,  16'sd2008, -16'sd1702,  16'sd1137, -16'sd399}
  };

endpackage

// File: rtl/compute_t_if.sv
// rtl/compute_t_if.sv - S' RAM read port and T RAM write port bundle
// master is the transform engine, slave is the memory side.
interface compute_t_if;
  logic [7:0]  SP_RAM_address;
  logic [31:0] SP_RAM_read_data;
  logic [7:0]  T_RAM_address;
  logic [31:0] T_RAM_write_data;
  logic        T_RAM_we;

  modport master (
    output SP_RAM_address,
    input  SP_RAM_read_data,
    output T_RAM_address,
    output T_RAM_write_data,
    output T_RAM_we
  );

  modport slave (
    input  SP_RAM_address,
    output SP_RAM_read_data,
    input  T_RAM_address,
    input  T_RAM_write_data,
    input  T_RAM_we
  );
endinterface

// File: rtl/idct_coeff_rom.sv
// rtl/idct_coeff_rom.sv - combinational coefficient pair lookup
// Returns C[2*kp][j] and C[2*kp+1][j] for the two multipliers.
module idct_coeff_rom
  import idct_pkg::*;
(
  input  logic [1:0]         kp,
  input  logic [2:0]         j,
  output logic signed [15:0] c_even,
  output logic signed [15:0] c_odd
);

  assign c_even = C_TABLE[{kp, 1'b0}][j];
  assign c_odd  = C_TABLE[{kp, 1'b1}][j];

endmodule

// File: rtl/compute_t.sv
// rtl/compute_t.sv - T = S' x C over one 8x8 block, 37 cycles per row
// Optional COMPUTE_T_ROUND_EN: add 128 before the >>>8 (round half up); default truncates.
module compute_t
  import idct_pkg::*;
(
  input  logic      Clock_50,
  input  logic      Resetn,
  input  logic      start,
  output logic      finish,
  compute_t_if.master ram
);

  state_t state, state_next;

  logic [2:0]         row;
  logic [4:0]         cnt;
  logic signed [15:0] s_row [8];
  logic signed [31:0] acc;
  logic signed [31:0] acc_sum;
  logic signed [31:0] p_even;
  logic signed [31:0] p_odd;
  logic signed [31:0] t_val;
  logic signed [15:0] c_even;
  logic signed [15:0] c_odd;
  logic [1:0]         kp;
  logic [2:0]         col;
  logic [1:0]         word_sel;

  // In MAC the counter splits as {column, pair}; in LOAD it is the fetch step.
  assign kp       = cnt[1:0];
  assign col      = cnt[4:2];
  assign word_sel = cnt[1:0] - 2'd1;

  idct_coeff_rom u_rom (
    .kp     (kp),
    .j      (col),
    .c_even (c_even),
    .c_odd  (c_odd)
  );

  assign p_even  = 32'(s_row[{kp, 1'b0}]) * 32'(c_even);
  assign p_odd   = 32'(s_row[{kp, 1'b1}]) * 32'(c_odd);
  assign acc_sum = ((kp == 2'd0) ? 32'sd0 : acc) + p_even + p_odd;

`ifdef COMPUTE_T_ROUND_EN
  assign t_val = (acc_sum + ROUND_BIAS) >>> T_SHIFT;
`else
  assign t_val = acc_sum >>> T_SHIFT;
`endif

  assign ram.SP_RAM_address = {3'b000, row, kp};

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE:       if (start) state_next = LOAD;
      LOAD:       if (cnt == 5'd4) state_next = MAC;
      MAC:        if (cnt == 5'd31) state_next = (row == 3'd7) ? WRITE_LAST : LOAD;
      WRITE_LAST: state_next = DONE;
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      row                  <= '0;
      cnt                  <= '0;
      acc                  <= '0;
      ram.T_RAM_we         <= 1'b0;
      ram.T_RAM_address    <= '0;
      ram.T_RAM_write_data <= '0;
      for (int i = 0; i < 8; i++) s_row[i] <= '0;
    end else begin
      ram.T_RAM_we <= 1'b0;
      case (state)
        IDLE: begin
          row <= '0;
          cnt <= '0;
        end
        LOAD: begin
          // Data for the address issued last cycle arrives now.
          if (cnt != 5'd0) begin
            s_row[{word_sel, 1'b0}] <= ram.SP_RAM_read_data[31:16];
            s_row[{word_sel, 1'b1}] <= ram.SP_RAM_read_data[15:0];
          end
          cnt <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
        end
        MAC: begin
          acc <= acc_sum;
          cnt <= cnt + 5'd1;
          if (kp == 2'd3) begin
            ram.T_RAM_we         <= 1'b1;
            ram.T_RAM_address    <= {2'b00, row, col};
            ram.T_RAM_write_data <= t_val;
          end
          if (cnt == 5'd31) row <= row + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
